// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready flow control and status flags.
// Each stage resolves WIDTH/STAGES bits with chained 4-bit CLA groups; inter-stage carry is registered.
module pipelined_cla_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic [TAG_W-1:0] out_tag
);

   // Guarded copies keep the derived constants legal while the check below reports the error.
   localparam int unsigned DIV = (STAGES == 0) ? 4 : 4 * STAGES;
   localparam int unsigned ST  = (STAGES == 0) ? 1 : STAGES;
   localparam int unsigned SEG = WIDTH / ST;
   localparam int unsigned NG  = SEG / 4;
   localparam int unsigned NR  = (ST > 1) ? ST - 1 : 1;

   if (STAGES == 0 || (WIDTH % DIV) != 0) begin : g_param_err
      $error("pipelined_cla_addsub: STAGES must be >= 1 and WIDTH a multiple of 4*STAGES");
   end

   // Returns {carry out, carry into bit 3, sum[3:0]} of one 4-bit look-ahead group.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
             (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], c[3], p ^ c[3:0]};
   endfunction

   logic             adv;

   logic [NR-1:0]    vld_q, vld_d;
   logic [NR-1:0]    c_q, c_d;
   logic [WIDTH-1:0] a_q   [NR];
   logic [WIDTH-1:0] a_d   [NR];
   logic [WIDTH-1:0] bx_q  [NR];
   logic [WIDTH-1:0] bx_d  [NR];
   logic [WIDTH-1:0] s_q   [NR];
   logic [WIDTH-1:0] s_d   [NR];
   logic [TAG_W-1:0] tag_q [NR];
   logic [TAG_W-1:0] tag_d [NR];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   logic [WIDTH-1:0] st_a, st_bx, st_s;
   logic             st_c, st_cmsb, st_v;
   logic [TAG_W-1:0] st_t;
   logic [5:0]       grp;

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   always_comb begin
      vld_d       = '0;
      c_d         = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         a_d[i]   = '0;
         bx_d[i]  = '0;
         s_d[i]   = '0;
         tag_d[i] = '0;
      end
      out_valid_d = 1'b0;
      sum_d       = '0;
      cout_d      = 1'b0;
      ovf_d       = 1'b0;
      zero_d      = 1'b0;
      neg_d       = 1'b0;
      out_tag_d   = '0;
      st_a        = '0;
      st_bx       = '0;
      st_s        = '0;
      st_c        = 1'b0;
      st_cmsb     = 1'b0;
      st_v        = 1'b0;
      st_t        = '0;
      grp         = '0;

      for (int unsigned k = 0; k < ST; k++) begin
         if (k == 0) begin
            st_a  = a;
            st_bx = b ^ {WIDTH{mode}};
            st_s  = '0;
            st_c  = cin;
            st_v  = in_valid;
            st_t  = in_tag;
         end else begin
            st_a  = a_q[k-1];
            st_bx = bx_q[k-1];
            st_s  = s_q[k-1];
            st_c  = c_q[k-1];
            st_v  = vld_q[k-1];
            st_t  = tag_q[k-1];
         end
         st_cmsb = 1'b0;
         for (int unsigned g = 0; g < NG; g++) begin
            grp = cla4(st_a[k*SEG+4*g +: 4], st_bx[k*SEG+4*g +: 4], st_c);
            st_s[k*SEG+4*g +: 4] = grp[3:0];
            st_cmsb = grp[4];
            st_c    = grp[5];
         end
         if (k + 1 < ST) begin
            vld_d[k] = st_v;
            a_d[k]   = st_a;
            bx_d[k]  = st_bx;
            s_d[k]   = st_s;
            c_d[k]   = st_c;
            tag_d[k] = st_t;
         end else begin
            out_valid_d = st_v;
            sum_d       = st_s;
            cout_d      = st_c;
            ovf_d       = st_c ^ st_cmsb;
            zero_d      = (st_s == '0);
            neg_d       = st_s[WIDTH-1];
            out_tag_d   = st_t;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         c_q         <= '0;
         for (int unsigned i = 0; i < NR; i++) begin
            a_q[i]   <= '0;
            bx_q[i]  <= '0;
            s_q[i]   <= '0;
            tag_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         out_tag_q   <= '0;
      end else if (adv) begin
         vld_q       <= vld_d;
         c_q         <= c_d;
         for (int unsigned i = 0; i < NR; i++) begin
            a_q[i]   <= a_d[i];
            bx_q[i]  <= bx_d[i];
            s_q[i]   <= s_d[i];
            tag_q[i] <= tag_d[i];
         end
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: directed corner cases, back-pressure, reset, random traffic.
module tb_pipelined_cla_addsub;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 2;
   localparam int unsigned TAG_W  = 4;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
      logic             neg;
      logic [TAG_W-1:0] tag;
   } res_t;

   logic             clk, rst;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] a, b, sum;
   logic             cin, mode, cout, ovf, zero, neg;
   logic [TAG_W-1:0] in_tag, out_tag;
   res_t             dut_res;

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_pop = 0;
   res_t sb_q[$];

   pipelined_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .mode(mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .out_tag(out_tag)
   );

   assign dut_res = {sum, cout, ovf, zero, neg, out_tag};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s (t=%0t)", name, msg, $time);
   endtask

   // Reference: plain wide addition, overflow from operand/result signs.
   function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, input logic md, input logic [TAG_W-1:0] t);
      logic [WIDTH-1:0] yx;
      logic [WIDTH:0]   full;
      res_t             r;
      yx     = md ? ~y : y;
      full   = {1'b0, x} + {1'b0, yx} + {{WIDTH{1'b0}}, ci};
      r.sum  = full[WIDTH-1:0];
      r.cout = full[WIDTH];
      r.ovf  = (x[WIDTH-1] == yx[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
      r.zero = (r.sum == '0);
      r.neg  = r.sum[WIDTH-1];
      r.tag  = t;
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] pick();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(WIDTH-1){1'b0}}};
         3:       v = {1'b0, {(WIDTH-1){1'b1}}};
         default: v = WIDTH'($urandom);
      endcase
      return v;
   endfunction

   // Scoreboard producer.
   initial forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) sb_q.push_back(model(a, b, cin, mode, in_tag));
   end

   // Monitor: handshake results, output hold under stall, in_ready rule.
   initial begin
      logic             hold_pend;
      logic [WIDTH+TAG_W+4:0] prev;
      res_t             exp;
      hold_pend = 1'b0;
      prev      = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) check("hold", 64'({out_valid, dut_res}), 64'(prev));
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  fail("unexpected_out", "result with empty scoreboard");
               end else begin
                  exp = sb_q.pop_front();
                  n_pop++;
                  check("result", 64'(dut_res), 64'(exp));
               end
            end
            hold_pend = out_valid && !out_ready;
            prev      = {out_valid, dut_res};
         end
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Called right after a posedge; returns #1 after the accepting edge.
   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                       input logic md, input logic [TAG_W-1:0] t);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      cin      = ci;
      mode     = md;
      in_tag   = t;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
      end
      check("send_accept", 64'(acc), 64'(1));
      #1 in_valid = 1'b0;
   endtask

   task automatic directed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic ci, input logic md, input logic [TAG_W-1:0] t,
                           input logic [WIDTH+3:0] exp_flags);
      send(x, y, ci, md, t);
      for (int i = 0; i < int'(STAGES); i++) begin
         if (i > 0) @(posedge clk);
         @(negedge clk);
         if (i < int'(STAGES) - 1) check("lat_early", 64'(out_valid), 64'(0));
      end
      check("lat_valid", 64'(out_valid), 64'(1));
      check("direct_res", 64'({sum, cout, ovf, zero, neg}), 64'(exp_flags));
      @(posedge clk);
      #1;
   endtask

   task automatic back_pressure();
      logic found;
      int   pops0;
      pops0     = n_pop;
      found     = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            for (int j = 0; j < 5; j++)
               send(pick(), pick(), 1'($urandom), 1'($urandom), TAG_W'(j + 8));
         end
         begin
            for (int n = 0; n < 50 && !found; n++) begin
               @(negedge clk);
               found = out_valid;
            end
            check("bp_first_valid", 64'(found), 64'(1));
            for (int s = 0; s < 3; s++) begin
               if (s > 0) @(negedge clk);
               check("bp_in_ready_low", 64'(in_ready), 64'(0));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (STAGES + 6) @(posedge clk);
      #1;
      check("bp_drain", 64'(sb_q.size()), 64'(0));
      check("bp_count", 64'(n_pop - pops0), 64'(5));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; mode = 1'b0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_outs", 64'({out_valid, dut_res}), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3, {32'h0000_0000, 4'b1010});
      directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'd5, {32'h7FFF_FFFF, 4'b1100});
      directed(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd6, {32'h0001_0000, 4'b0000});
      directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd7, {32'h8000_0000, 4'b0101});

      back_pressure();

      // Flush two in-flight operations with a one-cycle reset.
      send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 4'd1);
      send(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, 4'd2);
      rst = 1'b1;
      sb_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_outs", 64'({out_valid, dut_res}), 64'(0));
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale", 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 4'd9, {32'h0123_4567, 4'b1000});

      for (int cyc = 0; cyc < 12000; cyc++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = pick();
         b         = pick();
         cin       = 1'($urandom);
         mode      = 1'($urandom);
         in_tag    = TAG_W'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (STAGES + 4) @(posedge clk);
      #1;
      check("final_drain", 64'(sb_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
